// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_uart_pkg                                                   |
// | Purpose  : Shared states and defaults for the FIFO-fed UART transmitter.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package fifo_uart_pkg;

  localparam int   c_DATA_W_DEFAULT       = 8;
  localparam int   c_CLKS_PER_BIT_DEFAULT = 16;
  localparam logic c_LINE_IDLE            = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_baud.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_baud_tick                                                  |
// | Purpose  : Bit-period counter; pulses o_tick on the last cycle of a bit.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_baud_tick
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Wrap is explicit so non-power-of-two bit periods count correctly.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt == c_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_uart_tx                                                    |
// | Purpose  : Pops bytes from an upstream FIFO and sends them as UART frames. |
// |            Define FIFO_UART_TX_PARITY_EN to add an even-parity bit.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_W       = c_DATA_W_DEFAULT,
  parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy
);

  localparam int                 c_BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_W - 1);

  tx_state_t           r_state;
  tx_state_t           w_state_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [DATA_W-1:0]   w_shift_dn;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [c_BIT_W-1:0]  w_bit_cnt_nxt;
  logic                r_tx;
  logic                w_tx_nxt;
  logic                r_rd_en;
  logic                w_rd_en_nxt;
  logic                r_busy;
  logic                w_baud_clear;
  logic                w_tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                r_parity;
  logic                w_parity_nxt;
`endif

  // Bit timing restarts from zero on the LOAD edge so START is a full bit.
  assign w_baud_clear = (r_state == ST_IDLE) || (r_state == ST_FETCH) ||
                        (r_state == ST_LOAD);
  assign w_shift_dn   = r_shift >> 1;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_baud_clear),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= c_LINE_IDLE;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_nxt      = r_tx;
    w_rd_en_nxt   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = c_LINE_IDLE;
        if (!fifo_empty) begin
          w_rd_en_nxt = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_shift_nxt   = fifo_data;
        w_bit_cnt_nxt = '0;
        w_tx_nxt      = 1'b0;
        w_state_nxt   = ST_START;
`ifdef FIFO_UART_TX_PARITY_EN
        w_parity_nxt  = ^fifo_data;
`endif
      end
      ST_START: begin
        if (w_tick) begin
          w_tx_nxt    = r_shift[0];
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == c_LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
            w_tx_nxt    = r_parity;
            w_state_nxt = ST_PARITY;
`else
            w_tx_nxt    = c_LINE_IDLE;
            w_state_nxt = ST_STOP;
`endif
          end else begin
            // tx is registered, so the next bit is taken from the shifted value.
            w_shift_nxt   = w_shift_dn;
            w_tx_nxt      = w_shift_dn[0];
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_tx_nxt    = c_LINE_IDLE;
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          w_tx_nxt    = c_LINE_IDLE;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_tx_nxt    = c_LINE_IDLE;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign fifo_rd_en = r_rd_en;
  assign tx         = r_tx;
  assign busy       = r_busy;

endmodule
`default_nettype wire
